// File: rtl/wd_window_supervisor.sv
// Windowed watchdog: CLOSED (kick illegal) then OPEN (kick legal) phases timed by an external frame_window counter.
// States IDLE=0 | CLR=1 (clearing counter) | CLOSED=2 | OPEN=3 | SRST=4 (timed system reset).
module wd_window_supervisor #(
  parameter logic [7:0] CLOSED_LEN = 8'd20,
  parameter logic [7:0] OPEN_LEN   = 8'd40,
  parameter int         FCW        = 4,
  parameter int         MAX_FAULTS = 3,
  parameter int         HEAL_CNT   = 4,
  parameter int         SRST_LEN   = 16
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_en,
  input  logic           i_kick,
  input  logic           i_fwovr,
  output logic           o_wdrst,
  output logic           o_wdsrvc,
  output logic [7:0]     o_fwlen,
  output logic           o_early,
  output logic           o_late,
  output logic           o_sysrst,
  output logic [FCW-1:0] o_fault_cnt,
  output logic [2:0]     o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_CLOSED = 3'd2,
    S_OPEN   = 3'd3,
    S_SRST   = 3'd4
  } state_t;

  localparam int HCW = $clog2(HEAL_CNT + 1);
  localparam int SCW = $clog2(SRST_LEN + 1);
  localparam logic [FCW-1:0] FAULT_MAX = FCW'(MAX_FAULTS);
  localparam logic [FCW-1:0] FAULT_SAT = '1;
  localparam logic [HCW-1:0] HEAL_LAST = HCW'(HEAL_CNT - 1);
  localparam logic [SCW-1:0] SRST_LOAD = SCW'(SRST_LEN - 1);

  state_t         r_state;
  logic           r_tgt_open;
  logic [HCW-1:0] r_heal_cnt;
  logic [SCW-1:0] r_srst_cnt;
  logic           r_wdrst;
  logic           r_wdsrvc;
  logic [7:0]     r_fwlen;
  logic           r_early;
  logic           r_late;
  logic           r_sysrst;
  logic [FCW-1:0] r_fault_cnt;

  logic           w_fault;
  logic [FCW-1:0] w_fault_inc;

  // A kick always wins over a coincident expiry: early in CLOSED, valid in OPEN.
  assign w_fault     = ((r_state == S_CLOSED) && i_kick) ||
                       ((r_state == S_OPEN) && !i_kick && i_fwovr);
  assign w_fault_inc = (r_fault_cnt == FAULT_SAT) ? r_fault_cnt : r_fault_cnt + FCW'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_tgt_open  <= 1'b0;
      r_heal_cnt  <= '0;
      r_srst_cnt  <= '0;
      r_wdrst     <= 1'b1;
      r_wdsrvc    <= 1'b0;
      r_fwlen     <= CLOSED_LEN;
      r_early     <= 1'b0;
      r_late      <= 1'b0;
      r_sysrst    <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      r_wdsrvc <= 1'b0;
      r_early  <= 1'b0;
      r_late   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wdrst <= 1'b1;
          r_fwlen <= CLOSED_LEN;
          if (i_en && !i_fwovr) begin
            r_state <= S_CLOSED;
            r_wdrst <= 1'b0;
          end
        end
        S_CLR: begin
          if (!i_en) begin
            r_state <= S_IDLE;
            r_fwlen <= CLOSED_LEN;
          end else if (!i_fwovr) begin
            r_wdrst <= 1'b0;
            r_state <= r_tgt_open ? S_OPEN : S_CLOSED;
          end
        end
        S_CLOSED, S_OPEN: begin
          if (!i_en) begin
            r_state <= S_IDLE;
            r_wdrst <= 1'b1;
            r_fwlen <= CLOSED_LEN;
          end else if (w_fault) begin
            r_early     <= (r_state == S_CLOSED);
            r_late      <= (r_state == S_OPEN);
            r_fault_cnt <= w_fault_inc;
            r_heal_cnt  <= '0;
            r_wdrst     <= 1'b1;
            r_fwlen     <= CLOSED_LEN;
            r_tgt_open  <= 1'b0;
            if (w_fault_inc == FAULT_MAX) begin
              r_state    <= S_SRST;
              r_sysrst   <= 1'b1;
              r_srst_cnt <= SRST_LOAD;
            end else begin
              r_state <= S_CLR;
            end
          end else if ((r_state == S_OPEN) && i_kick) begin
            r_wdsrvc   <= 1'b1;
            r_wdrst    <= 1'b1;
            r_fwlen    <= CLOSED_LEN;
            r_tgt_open <= 1'b0;
            r_state    <= S_CLR;
            if (r_heal_cnt == HEAL_LAST) begin
              r_heal_cnt <= '0;
              if (r_fault_cnt != '0) r_fault_cnt <= r_fault_cnt - FCW'(1);
            end else begin
              r_heal_cnt <= r_heal_cnt + HCW'(1);
            end
          end else if ((r_state == S_CLOSED) && i_fwovr) begin
            r_wdrst    <= 1'b1;
            r_fwlen    <= OPEN_LEN;
            r_tgt_open <= 1'b1;
            r_state    <= S_CLR;
          end
        end
        S_SRST: begin
          // Enable is deliberately ignored here so the reset pulse is never cut short.
          if (r_srst_cnt == '0) begin
            r_state     <= S_IDLE;
            r_sysrst    <= 1'b0;
            r_fault_cnt <= '0;
            r_heal_cnt  <= '0;
          end else begin
            r_srst_cnt <= r_srst_cnt - SCW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_wdrst  <= 1'b1;
          r_sysrst <= 1'b0;
          r_fwlen  <= CLOSED_LEN;
        end
      endcase
    end
  end

  assign o_wdrst     = r_wdrst;
  assign o_wdsrvc    = r_wdsrvc;
  assign o_fwlen     = r_fwlen;
  assign o_early     = r_early;
  assign o_late      = r_late;
  assign o_sysrst    = r_sysrst;
  assign o_fault_cnt = r_fault_cnt;
  assign o_state     = r_state;

endmodule
